eth_rx_frame_fifo: RTL
======================

# eth_rx_frame_fifo

Store-and-forward receive frame FIFO sitting directly downstream of the 10G MAC/PCS receive AXIS output (`m00_axis_*`), in the receive user clock domain. It accepts one 32-bit beat per cycle with no backpressure, holds each frame until its final beat arrives, and then either commits it or discards it. A frame is discarded when it ends with an error flag or when it overflows the buffer. Committed frames are replayed on a backpressured AXIS master, so downstream logic only ever sees complete, error-free frames.

## Interface

Parameters:
- `DEPTH_WORDS`, 512: buffer depth in 32-bit words; power of two, ≥ 16.
- `CNT_W`, 16: width of the saturating statistics counters.

Ports:
- `i_clk`, in, 1: receive user clock; all logic is on this clock.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `s00_axis_tdata`, in, 32: receive data from the MAC.
- `s00_axis_tkeep`, in, 4: byte enables; stored unmodified.
- `s00_axis_tvalid`, in, 1: beat valid. There is no tready; every valid beat is consumed.
- `s00_axis_tlast`, in, 1: last beat of the frame.
- `s00_axis_tuser`, in, 1: frame error; sampled only on the tlast beat.
- `m00_axis_tdata`, out, 32: committed frame data.
- `m00_axis_tkeep`, out, 4: committed byte enables.
- `m00_axis_tvalid`, out, 1: output beat valid.
- `m00_axis_tready`, in, 1: downstream ready.
- `m00_axis_tlast`, out, 1: last beat of the committed frame.
- `o_err_drop_count`, out, `CNT_W`: frames dropped because tuser was set; saturating.
- `o_ovf_drop_count`, out, `CNT_W`: frames dropped on overflow; saturating.

## Operation

Storage and pointers:
- Memory word is 37 bits: `{tlast, tkeep, tdata}`. Address width is `A = log2(DEPTH_WORDS)`.
- Three pointers, each `A+1` bits: `wr_ptr` (speculative), `commit_ptr`, `rd_ptr`. Pointers wrap modulo `2·DEPTH_WORDS`.
- Fill level is `wr_ptr − rd_ptr`, computed modulo `2^(A+1)`. The buffer is full when fill equals `DEPTH_WORDS`.

Write-side FSM, states `IDLE/RECV` and `DROP`. Each case applies when `s00_axis_tvalid` is high:
- **In RECV, buffer not full:** write the beat at `wr_ptr[A-1:0]`; `wr_ptr++`.
  - If tlast and !tuser: `commit_ptr ← wr_ptr+1`.
  - If tlast and tuser: `wr_ptr ← commit_ptr`; `o_err_drop_count++`.
- **In RECV, buffer full:** do not write the beat; `wr_ptr ← commit_ptr`; `o_ovf_drop_count++`.
  - If the beat is tlast, stay in RECV. Otherwise go to DROP.
- **In DROP:** discard every beat. On the tlast beat, return to RECV. tuser is ignored, so a frame is never counted twice.
- tuser on a non-last beat has no effect. Gaps in tvalid mid-frame are legal.
- A frame longer than `DEPTH_WORDS` is always dropped as overflow.

Read side:
- The read side is a 1-entry output register fed from memory.
- It is loaded whenever `rd_ptr ≠ commit_ptr` and either the register is empty or the register is being consumed this cycle (`m00_axis_tvalid && m00_axis_tready`). A load increments `rd_ptr`.
- Output fields hold stable while tvalid is high and tready is low.
- Uncommitted words are never read.

Counters:
- Counters saturate at `2^CNT_W − 1` and never wrap.
- They are cleared only by reset.

## Timing

- **Reset:** all pointers, FSM state (RECV), the output register and the counters go to 0. `m00_axis_tvalid`, `tlast`, `tdata` and `tkeep` are 0.
  - A reset mid-frame on either side discards everything buffered; no partial frame is ever emitted afterwards.
- **Commit-to-output latency:** tlast is accepted at edge N and the buffer was empty with the output register idle.
  - `commit_ptr` updates at edge N.
  - The memory read is issued in cycle N+1.
  - `m00_axis_tvalid` is high after edge N+2.
- **Throughput:** with `m00_axis_tready` held high, one beat is output per cycle with no bubbles within or between committed frames.
- **Simultaneous events:**
  - Commit and output load in the same cycle: the load uses the pre-update `commit_ptr`.
  - Read freeing a slot in the same cycle a write arrives: fullness is evaluated with the registered `rd_ptr`, i.e. conservatively.
  - Drop rollback and output load in the same cycle: no interaction, since rollback never goes below `commit_ptr`.
- The counter increment is visible one cycle after the triggering beat.

## Test plan

All scenarios use `DEPTH_WORDS=16`.

1. **Single clean frame.** Send 4 beats, tdata 0x0–0x3, last tkeep 4'b0011, tuser=0, tready=1.
   - Output shows the same 4 beats, with tvalid rising 2 cycles after the tlast edge.
   - tlast only on the 4th beat; counters stay 0.
2. **Errored frame between good ones.** Send frame A (3 beats), then frame B (5 beats, tuser=1 on tlast), then frame C (2 beats).
   - Output is A then C only.
   - `o_err_drop_count=1`.
3. **Overflow.** Hold tready=0 and send a 20-beat frame.
   - Nothing is output; `o_ovf_drop_count=1`.
   - A following 3-beat frame is output correctly once tready=1.
4. **Backpressure.** Send three 6-beat frames back-to-back while toggling tready randomly.
   - All 18 beats appear in order.
   - Output is stable while stalled; no loss and no duplication.
5. **Exactly full, then wrap.** With tready=0, send a 16-beat frame.
   - The frame is committed; then release tready and it is output intact.
   - Repeat 3 times so the pointers wrap; every frame is intact.
6. **Reset mid-frame and saturation.**
   - Assert `i_reset` after beat 2 of a 5-beat frame: all outputs are 0, and the next frame is output clean.
   - Drop `2^16+3` errored frames: `o_err_drop_count` holds at 0xFFFF.

Source files
------------

// File: rtl/eth_rx_frame_fifo_if.sv
// AXI-stream style beat bundle shared by the MAC-side input and the
// downstream output of the receive frame FIFO.
// Signals: tdata[31:0], tkeep[3:0], tvalid, tready, tlast, tuser.
// master drives the beat and samples tready; slave is the reverse.
interface eth_rx_frame_fifo_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame FIFO: buffers each MAC frame, commits
// it on a clean tlast, drops it on tuser error or buffer overflow.
// Ports: i_clk, i_reset (async, active high), s00_axis (slave, always
// ready), m00_axis (master, backpressured), o_err_drop_count and
// o_ovf_drop_count (saturating drop statistics).
module eth_rx_frame_fifo #(
    parameter int DEPTH_WORDS = 512,
    parameter int CNT_W       = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    eth_rx_frame_fifo_if.slave        s00_axis,
    eth_rx_frame_fifo_if.master       m00_axis,
    output logic [CNT_W-1:0]          o_err_drop_count,
    output logic [CNT_W-1:0]          o_ovf_drop_count
);
    localparam int A = $clog2(DEPTH_WORDS);
    localparam logic [A:0]       DEPTH_P = (A + 1)'(DEPTH_WORDS);
    localparam logic [A:0]       PTR_ONE = (A + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        RECV = 1'b0,
        DROP = 1'b1
    } wstate_e;

    wstate_e          state_q;
    logic [A:0]       wr_ptr_q;
    logic [A:0]       commit_ptr_q;
    logic [A:0]       rd_ptr_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] ovf_cnt_q;

    logic [36:0]      mem [DEPTH_WORDS];
    logic [36:0]      ram_q;
    logic             ram_vld_q;

    logic             out_vld_q;
    logic             out_last_q;
    logic [3:0]       out_keep_q;
    logic [31:0]      out_data_q;

    logic [A:0]       fill;
    logic             full;
    logic             wr_en;
    logic             out_load;
    logic             rd_en;

    // Fullness uses the registered read pointer, so a slot freed this
    // cycle only becomes usable next cycle.
    assign fill  = wr_ptr_q - rd_ptr_q;
    assign full  = (fill == DEPTH_P);
    assign wr_en = s00_axis.tvalid && (state_q == RECV) && !full;

    // Two-stage read: RAM output register, then the output register.
    // A RAM read is only issued when its result has somewhere to go,
    // which keeps full throughput without a skid buffer.
    assign out_load = ram_vld_q && (!out_vld_q || m00_axis.tready);
    assign rd_en    = (rd_ptr_q != commit_ptr_q)
                   && (!ram_vld_q || out_load);

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[A-1:0]] <= {s00_axis.tlast,
                                     s00_axis.tkeep,
                                     s00_axis.tdata};
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr_q[A-1:0]];
        end
    end

    // Write-side FSM: speculative write pointer rolls back to the last
    // committed frame boundary on error or overflow.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= RECV;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            err_cnt_q    <= '0;
            ovf_cnt_q    <= '0;
        end else if (s00_axis.tvalid) begin
            unique case (state_q)
                RECV: begin
                    if (!full) begin
                        wr_ptr_q <= wr_ptr_q + PTR_ONE;
                        if (s00_axis.tlast) begin
                            if (s00_axis.tuser) begin
                                wr_ptr_q <= commit_ptr_q;
                                if (err_cnt_q != '1)
                                    err_cnt_q <= err_cnt_q + CNT_ONE;
                            end else begin
                                commit_ptr_q <= wr_ptr_q + PTR_ONE;
                            end
                        end
                    end else begin
                        wr_ptr_q <= commit_ptr_q;
                        if (ovf_cnt_q != '1)
                            ovf_cnt_q <= ovf_cnt_q + CNT_ONE;
                        if (!s00_axis.tlast)
                            state_q <= DROP;
                    end
                end
                DROP: begin
                    // tuser is ignored here: the frame is already counted.
                    if (s00_axis.tlast)
                        state_q <= RECV;
                end
                default: state_q <= RECV;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_ptr_q   <= '0;
            ram_vld_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_keep_q <= '0;
            out_data_q <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                ram_vld_q <= 1'b1;
            end else if (out_load) begin
                ram_vld_q <= 1'b0;
            end
            if (out_load) begin
                out_vld_q  <= 1'b1;
                out_last_q <= ram_q[36];
                out_keep_q <= ram_q[35:32];
                out_data_q <= ram_q[31:0];
            end else if (m00_axis.tready) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign s00_axis.tready = 1'b1;

    assign m00_axis.tvalid = out_vld_q;
    assign m00_axis.tlast  = out_last_q;
    assign m00_axis.tkeep  = out_keep_q;
    assign m00_axis.tdata  = out_data_q;
    assign m00_axis.tuser  = 1'b0;

    assign o_err_drop_count = err_cnt_q;
    assign o_ovf_drop_count = ovf_cnt_q;
endmodule
